// File: rtl/alu_ctrl_pkg.sv
// Shared types and command helpers for the ALU request arbiter.
// Command values are compared zero-extended to 8 bits, so CMD_WIDTH must not exceed 8.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic err;
    logic oflow;
    logic cout;
    logic g;
    logic l;
    logic e;
  } alu_flags_t;

  localparam logic [7:0] MUL_CMD_A     = 8'd9;
  localparam logic [7:0] MUL_CMD_B     = 8'd10;
  localparam logic [7:0] MAX_ARITH_CMD = 8'd12;
  localparam logic [7:0] MAX_LOGIC_CMD = 8'd13;

  function automatic logic is_mul(input logic mode, input logic [7:0] cmd);
    return mode && ((cmd == MUL_CMD_A) || (cmd == MUL_CMD_B));
  endfunction

  function automatic logic is_illegal(input logic mode, input logic [7:0] cmd);
    return mode ? (cmd > MAX_ARITH_CMD) : (cmd > MAX_LOGIC_CMD);
  endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr+1 (mod NUM_REQ).
module alu_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic found_s;
  logic hit_s;
  int   c_s;

  // Scan the ring starting just after the last winner.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    c_s     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c_s        = (int'(ptr) + k) % NUM_REQ;
      hit_s      = ~found_s & req[c_s];
      grant[c_s] = hit_s;
      idx        = hit_s ? IDX_W'(c_s) : idx;
      found_s    = found_s | hit_s;
    end
    any = found_s;
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin grants and per-command latency.
// Optional macro ALU_CMD_CHECK_EN: illegal commands are answered with err without touching the ALU.
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4,
  parameter int ALU_LAT   = 1,
  parameter int MUL_LAT   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]  req_opa,
  input  logic [NUM_REQ*WIDTH-1:0]  req_opb,
  input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
  input  logic [NUM_REQ*2-1:0]      req_inp_valid,
  input  logic [NUM_REQ-1:0]        req_mode,
  input  logic [NUM_REQ-1:0]        req_cin,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [WIDTH+1:0]          rsp_res,
  output logic [5:0]                rsp_flags,
  output logic [WIDTH-1:0]          alu_opa,
  output logic [WIDTH-1:0]          alu_opb,
  output logic [CMD_WIDTH-1:0]      alu_cmd,
  output logic [1:0]                alu_inp_valid,
  output logic                      alu_ce,
  output logic                      alu_cin,
  output logic                      alu_mode,
  input  logic [WIDTH+1:0]          alu_res,
  input  logic                      alu_err,
  input  logic                      alu_oflow,
  input  logic                      alu_cout,
  input  logic                      alu_g,
  input  logic                      alu_l,
  input  logic                      alu_e
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int LAT_MAX = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
  logic [1:0]           inpv_q, inpv_d;
  logic                 mode_q, mode_d, cin_q, cin_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH+1:0]     res_q, res_d;
  alu_flags_t           flags_q, flags_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic                 alu_ce_q, alu_ce_d;
  logic                 run_q, run_d;

  logic [NUM_REQ-1:0]   gnt_s;
  logic [IDX_W-1:0]     gidx_s;
  logic                 any_s;
  logic [NUM_REQ-1:0]   req_ready_s;
  logic                 illegal_s;

  alu_rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (gnt_s),
    .idx   (gidx_s),
    .any   (any_s)
  );

  // Illegal-command screening of the currently selected requester.
`ifdef ALU_CMD_CHECK_EN
  assign illegal_s = is_illegal(req_mode[gidx_s], 8'(req_cmd[gidx_s*CMD_WIDTH +: CMD_WIDTH]));
`else
  assign illegal_s = 1'b0;
`endif

  // Next-state, operand latch, wait counter and response capture.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    cmd_d       = cmd_q;
    inpv_d      = inpv_q;
    mode_d      = mode_q;
    cin_d       = cin_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    flags_d     = flags_q;
    req_ready_s = '0;
    run_d       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (run_q && any_s) begin
          req_ready_s = gnt_s;
          ptr_d       = gidx_s;
          if (illegal_s) begin
            res_d   = '0;
            flags_d = '{err: 1'b1, default: 1'b0};
            state_d = ST_RESP;
          end else begin
            opa_d   = req_opa[gidx_s*WIDTH +: WIDTH];
            opb_d   = req_opb[gidx_s*WIDTH +: WIDTH];
            cmd_d   = req_cmd[gidx_s*CMD_WIDTH +: CMD_WIDTH];
            inpv_d  = req_inp_valid[gidx_s*2 +: 2];
            mode_d  = req_mode[gidx_s];
            cin_d   = req_cin[gidx_s];
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = is_mul(mode_q, 8'(cmd_q)) ? CNT_W'(MUL_LAT) : CNT_W'(ALU_LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Sample the ALU on the last wait edge while ce is still high.
        if (cnt_q <= CNT_W'(1)) begin
          res_d   = alu_res;
          flags_d = '{err: alu_err, oflow: alu_oflow, cout: alu_cout,
                      g: alu_g, l: alu_l, e: alu_e};
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    alu_ce_d    = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    rsp_valid_d = (state_d == ST_RESP) ? (ONE_HOT0 << ptr_d) : '0;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      opa_q       <= '0;
      opb_q       <= '0;
      cmd_q       <= '0;
      inpv_q      <= 2'b00;
      mode_q      <= 1'b0;
      cin_q       <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      flags_q     <= '0;
      rsp_valid_q <= '0;
      alu_ce_q    <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      cmd_q       <= cmd_d;
      inpv_q      <= inpv_d;
      mode_q      <= mode_d;
      cin_q       <= cin_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      rsp_valid_q <= rsp_valid_d;
      alu_ce_q    <= alu_ce_d;
      run_q       <= run_d;
    end
  end

  // run_q clears asynchronously, so the accept pulse is silent throughout reset.
  assign req_ready     = req_ready_s;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_res       = res_q;
  assign rsp_flags     = flags_q;
  assign alu_opa       = opa_q;
  assign alu_opb       = opb_q;
  assign alu_cmd       = cmd_q;
  assign alu_inp_valid = inpv_q;
  assign alu_ce        = alu_ce_q;
  assign alu_cin       = cin_q;
  assign alu_mode      = mode_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed, table-driven bench for alu_req_arbiter with a small behavioural ALU model.
module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_opa = '0;
  logic [31:0] req_opb = '0;
  logic [15:0] req_cmd = '0;
  logic [7:0]  req_inp_valid = '0;
  logic [3:0]  req_mode = '0;
  logic [3:0]  req_cin = '0;
  logic [3:0]  rsp_valid;
  logic [9:0]  rsp_res;
  logic [5:0]  rsp_flags;
  logic [7:0]  alu_opa, alu_opb;
  logic [3:0]  alu_cmd;
  logic [1:0]  alu_inp_valid;
  logic        alu_ce, alu_cin, alu_mode;
  logic [9:0]  m_res = '0;
  logic [5:0]  m_fl = '0;

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_req_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
    .req_inp_valid(req_inp_valid), .req_mode(req_mode), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_flags(rsp_flags),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
    .alu_inp_valid(alu_inp_valid), .alu_ce(alu_ce), .alu_cin(alu_cin),
    .alu_mode(alu_mode), .alu_res(m_res), .alu_err(m_fl[5]),
    .alu_oflow(m_fl[4]), .alu_cout(m_fl[3]), .alu_g(m_fl[2]),
    .alu_l(m_fl[1]), .alu_e(m_fl[0])
  );

  // ALU stand-in: returns {flags, result}.
  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] c, input logic m,
                                         input logic [1:0] iv);
    logic [9:0] r;
    logic [5:0] f;
    r = '0;
    f = '0;
    if (iv == 2'b00) f = 6'b100000;
    else if (m) begin
      case (c)
        4'd0:  begin r = {2'b00, a} + {2'b00, b}; f[3] = r[8]; end
        4'd8:  f[2:0] = {a > b, a < b, a == b};
        4'd9:  r = ({2'b00, a} + 10'd1) * ({2'b00, b} + 10'd1);
        4'd10: r = {1'b0, a, 1'b0} * {2'b00, b};
        default: f = 6'b100000;
      endcase
    end else begin
      case (c)
        4'd0:  r = {2'b00, a & b};
        4'd1:  r = {2'b00, a | b};
        default: f = 6'b100000;
      endcase
    end
    return {f, r};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_res <= '0;
      m_fl  <= '0;
    end else if (alu_ce) begin
      {m_fl, m_res} <= alu_fn(alu_opa, alu_opb, alu_cmd, alu_mode, alu_inp_valid);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic set_req(input int r, input logic m, input logic [3:0] c,
                         input logic [7:0] a, input logic [7:0] b, input logic [1:0] iv);
    req_opa[r*8 +: 8]       = a;
    req_opb[r*8 +: 8]       = b;
    req_cmd[r*4 +: 4]       = c;
    req_inp_valid[r*2 +: 2] = iv;
    req_mode[r]             = m;
    req_cin[r]              = 1'b0;
  endtask

  task automatic wait_grant(output int idx, output int t);
    idx = -1;
    t   = cyc;
    for (int i = 0; i < 30 && idx < 0; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (req_ready[k]) idx = k;
      t = cyc;
    end
  endtask

  typedef struct {
    int         r;
    logic       mode;
    logic [3:0] cmd;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [1:0] iv;
    logic [9:0] res;
    logic [5:0] flags;
    int         lat;
    int         ce;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    int t0, t1, ce_cnt, idx;
    bit got;
    logic [3:0] oh;
    oh = 4'b0001 << v.r;
    set_req(v.r, v.mode, v.cmd, v.opa, v.opb, v.iv);
    req_valid[v.r] = 1'b1;
    wait_grant(idx, t0);
    chk("req_ready", req_ready, oh);
    @(posedge clk);
    #1 req_valid[v.r] = 1'b0;
    got = 1'b0;
    ce_cnt = 0;
    t1 = cyc;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (alu_ce) ce_cnt++;
      if (rsp_valid != 4'b0000) got = 1'b1;
      t1 = cyc;
    end
    chk("latency", t1 - t0, v.lat);
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_res", rsp_res, v.res);
    chk("rsp_flags", rsp_flags, v.flags);
    chk("ce_cycles", ce_cnt, v.ce);
    @(negedge clk);
    chk("rsp_pulse_end", rsp_valid, 4'b0000);
  endtask

  initial begin
    int idx, t, tprev;
    int exp_seq[4];
    logic [3:0] seen;
`ifdef ALU_CMD_CHECK_EN
    vecs[5] = '{1, 1'b1, 4'd14, 8'd1, 8'd1, 2'b11, 10'd0, 6'b100000, 1, 0};
`else
    vecs[5] = '{1, 1'b1, 4'd14, 8'd1, 8'd1, 2'b11, 10'd0, 6'b100000, 3, 2};
`endif
    vecs[0] = '{0, 1'b1, 4'd0, 8'd10, 8'd5, 2'b11, 10'd15, 6'b000000, 3, 2};
    vecs[1] = '{1, 1'b1, 4'd9, 8'd3, 8'd4, 2'b11, 10'd20, 6'b000000, 4, 3};
    vecs[2] = '{2, 1'b1, 4'd8, 8'd7, 8'd7, 2'b11, 10'd0, 6'b000001, 3, 2};
    vecs[3] = '{3, 1'b1, 4'd0, 8'd200, 8'd100, 2'b11, 10'd300, 6'b001000, 3, 2};
    vecs[4] = '{0, 1'b0, 4'd0, 8'hF0, 8'h3C, 2'b11, 10'h030, 6'b000000, 3, 2};
    vecs[6] = '{2, 1'b1, 4'd0, 8'd9, 8'd9, 2'b00, 10'd0, 6'b100000, 3, 2};
    vecs[7] = '{3, 1'b1, 4'd8, 8'd3, 8'd9, 2'b11, 10'd0, 6'b000010, 3, 2};

    // Reset with all requesters asking.
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, 4'd0, 8'(k), 8'd1, 2'b11);
    req_valid = 4'hF;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_alu_ce", alu_ce, 1'b0);
    chk("rst_rsp_res", rsp_res, 10'd0);
    chk("rst_alu_opa", alu_opa, 8'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Fairness: 0,1,2,3 then 0,2,0,2 with one grant per 4 cycles.
    tprev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(idx, t);
      chk("fair_all_idx", idx, k);
      if (k > 0) chk("fair_all_gap", t - tprev, 4);
      tprev = t;
    end
    @(posedge clk);
    #1 req_valid = 4'b0101;
    exp_seq = '{0, 2, 0, 2};
    for (int k = 0; k < 4; k++) begin
      wait_grant(idx, t);
      chk("fair_02_idx", idx, exp_seq[k]);
      chk("fair_02_gap", t - tprev, 4);
      tprev = t;
    end
    @(posedge clk);
    #1 req_valid = 4'b0000;
    repeat (6) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while a multiply sits in WAIT.
    set_req(1, 1'b1, 4'd9, 8'd3, 8'd4, 2'b11);
    req_valid[1] = 1'b1;
    wait_grant(idx, t);
    chk("mid_rst_grant", idx, 1);
    @(posedge clk);
    #1 req_valid = 4'b0000;
    @(posedge clk);
    #1 req_valid = 4'b1000;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ce", alu_ce, 1'b0);
    chk("mid_rst_ready", req_ready, 4'b0000);
    chk("mid_rst_opa", alu_opa, 8'd0);
    chk("mid_rst_flags", rsp_flags, 6'd0);
    seen = '0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("mid_rst_no_rsp", seen, 4'b0000);
    @(posedge clk);
    #1 rst = 1'b1;
    req_valid = 4'b1010;
    wait_grant(idx, t);
    chk("post_rst_grant", idx, 1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    seen = '0;
    for (int i = 0; i < 20 && seen == 4'b0000; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    chk("post_rst_rsp_valid", seen, 4'b0010);
    chk("post_rst_res", rsp_res, 10'd20);
    req_valid = 4'b0000;
    repeat (8) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one ALU instance between NUM_REQ requesters.
- Round-robin arbitration; accepts one complete operation per grant and drives the ALU operand/control pins.
- Holds ce through the command-dependent latency, then returns the result and flags to the granted requester.
- Sits between requester agents/blocks and the ALU port group (opa, opb, cmd, inp_valid, ce, cin, mode, res, err, oflow, cout, g, l, e).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width; ALU result is WIDTH+2.
- CMD_WIDTH, 4, command field width.
- ALU_LAT, 1, wait cycles for non-multiply commands (≥1).
- MUL_LAT, 2, wait cycles for multiply commands (mode=1, cmd 9 or 10).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- req_opa  in  NUM_REQ*WIDTH  packed operand A; slice i belongs to requester i.
- req_opb  in  NUM_REQ*WIDTH  packed operand B.
- req_cmd  in  NUM_REQ*CMD_WIDTH  packed command.
- req_inp_valid  in  NUM_REQ*2  packed operand-valid code.
- req_mode  in  NUM_REQ  1=arithmetic, 0=logical.
- req_cin  in  NUM_REQ  carry-in.
- rsp_valid  out  NUM_REQ  one-hot response pulse.
- rsp_res  out  WIDTH+2  result.
- rsp_flags  out  6  {err,oflow,cout,g,l,e}.
- alu_opa/alu_opb  out  WIDTH  ALU operands.
- alu_cmd  out  CMD_WIDTH; alu_inp_valid  out  2; alu_ce, alu_cin, alu_mode  out  1.
- alu_res  in  WIDTH+2; alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e  in  1.

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, RR pointer=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant the first requester at or after pointer+1 (modulo NUM_REQ).
  - Pulse req_ready[g] for 1 cycle, latch its fields, set pointer=g, go to ISSUE.
  - No requests: alu_ce=0, stay in IDLE.
- ISSUE: drive latched fields on the alu_* pins with alu_ce=1 for 1 cycle; load the wait counter with MUL_LAT if mode=1 and cmd∈{9,10}, else ALU_LAT; go to WAIT.
- WAIT:
  - alu_ce=1 and inputs held stable; counter decrements each cycle.
  - When it reaches 1, register alu_res and the flags at that edge and go to RESP.
- RESP: rsp_valid[g]=1 for exactly 1 cycle with the registered result; alu_ce=0; go to IDLE.
- Latency: accept at T → rsp_valid at T+2+LAT. Throughput is one op per 3+LAT cycles.
- Responses have no backpressure; the requester must sample on the rsp_valid pulse.
- Handshake:
  - A requester keeps req_valid and its fields stable until req_ready.
  - req_valid held after req_ready is a new request.
  - Requests arriving outside IDLE wait; nothing is dropped.
- inp_valid is passed through unchanged, and 2'b00 is forwarded; the ALU raises err and it is returned verbatim.
- The block never splits operands across cycles, so the ALU 16-cycle operand-wait window is never exercised. Single-operand codes are legal only for single-operand commands.
- rsp_res, rsp_flags and the alu_* pins hold their last values outside the RESP and ISSUE/WAIT states respectively; alu_ce=0 freezes the ALU.
- Reset mid-operation: the op is abandoned with no rsp_valid; the requester must re-request.

Optional Feature:
- Macro: ALU_CMD_CHECK_EN.
- Defined:
  - In IDLE, a granted op with an illegal cmd skips ISSUE/WAIT and goes directly to RESP. Illegal means mode=1 and cmd>12, or mode=0 and cmd>13.
  - Response: rsp_res=0, rsp_flags=6'b100000; alu_ce stays 0; latency 1 cycle after accept.
- Not defined: all commands are forwarded to the ALU.

Decomposition:
- Package alu_ctrl_pkg:
  - state enum;
  - packed flag struct {err,oflow,cout,g,l,e};
  - MUL_CMD_A=9, MUL_CMD_B=10, MAX_ARITH_CMD=12, MAX_LOGIC_CMD=13;
  - function is_mul(mode,cmd).
- Sub-module alu_rr_arb: request vector plus pointer in, one-hot grant plus index out (combinational).

Test Plan:
- Add: req0 only, opa=10, opb=5, cmd=0, mode=1, inp_valid=11 → req_ready[0] at T, alu_ce high T+1..T+2, rsp_valid[0] at T+3, rsp_res=15, flags=0.
- Fairness:
  - All 4 valid from reset → grants 0,1,2,3 in order, one per 4 cycles.
  - Then only req0 and req2 held → grants alternate 0,2,0,2.
- Multiply: mode=1, cmd=9, opa=3, opb=4 → alu_ce high 3 cycles, rsp_valid at T+4, rsp_res=20.
- Compare: mode=1, cmd=8, opa=7, opb=7 → rsp_flags e=1, g=l=0.
- Reset during WAIT: rst=0 → all outputs 0 immediately, no rsp_valid. After release, re-request → normal response; first grant goes to the lowest index valid requester.
- Illegal command: mode=1, cmd=14.
  - With ALU_CMD_CHECK_EN: rsp_valid at T+1, flags=100000, alu_ce never high.
  - Without it: ALU issued, the ALU's err is returned at T+3.
